window_gen: RTL

Streaming 3×3 window generator that sits upstream of the convolution datapath. It accepts raster-order pixels for three channels, one pixel per channel per beat. It buffers two previous image rows per channel and emits one packed 9-pixel window per channel on 90-bit buses. Those buses feed the convolution core's data inputs directly: stride 1, no padding.

---
 rtl/window_gen_pkg.sv | 15 +
 rtl/window_gen_line_buffer.sv | 28 ++
 rtl/window_gen.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/window_gen_pkg.sv
// Shared 3x3 window geometry and packing order, used by window_gen and the conv core.
package window_gen_pkg;

  localparam int DATA_W_DEF = 32'sd10;
  localparam int WIN_K      = 32'sd3;
  localparam int WIN_N      = WIN_K * WIN_K;
  localparam int BUS_W_DEF  = WIN_N * DATA_W_DEF;
  localparam int N_CH       = 32'sd3;

  // Element k = 3*wr + wc; wr=0 is the oldest row, wc=0 the oldest column.
  function automatic int elem_idx(input int wr, input int wc);
    return WIN_K * wr + wc;
  endfunction

endpackage

// File: rtl/window_gen_line_buffer.sv
// Shift-enabled delay line: o_data is the sample written DEPTH enables ago.
module line_buffer
  import window_gen_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int WIDTH = DATA_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Storage is deliberately left unreset; stale contents are gated out upstream.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      r_mem[0] <= i_data;
      for (int k = 1; k < DEPTH; k++) begin
        r_mem[k] <= r_mem[k-1];
      end
    end
  end

  assign o_data = r_mem[DEPTH-1];

endmodule

// File: rtl/window_gen.sv
// Streaming 3x3 window generator for three channels, stride 1, no padding.
module window_gen
  import window_gen_pkg::*;
#(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [DATA_W-1:0]       i_pixel0,
  input  logic [DATA_W-1:0]       i_pixel1,
  input  logic [DATA_W-1:0]       i_pixel2,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [WIN_N*DATA_W-1:0] o_busData0,
  output logic [WIN_N*DATA_W-1:0] o_busData1,
  output logic [WIN_N*DATA_W-1:0] o_busData2,
  output logic                    o_last
);

  localparam int BUS_W = WIN_N * DATA_W;
  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(2);
  localparam logic [RW-1:0] ROW_MIN  = RW'(2);

  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic              r_valid;
  logic              r_last;
  logic              w_accept;
  logic              w_produce;
  logic              w_col_end;
  logic              w_frame_end;
  logic [DATA_W-1:0] w_pix [N_CH];

  assign o_ready     = !r_valid || i_ready;
  assign w_accept    = i_valid && o_ready;
  assign w_col_end   = (r_col == COL_LAST);
  assign w_frame_end = w_col_end && (r_row == ROW_LAST);
  assign w_produce   = w_accept && (r_col >= COL_MIN) && (r_row >= ROW_MIN);

  assign w_pix[0] = i_pixel0;
  assign w_pix[1] = i_pixel1;
  assign w_pix[2] = i_pixel2;

  // Raster position of the next accepted pixel; wraps straight into the next frame.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_col_end) begin
        r_col <= '0;
        if (r_row == ROW_LAST) begin
          r_row <= '0;
        end else begin
          r_row <= r_row + RW'(1);
        end
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // Output valid/last hold under back-pressure and drop after a handoff with no new window.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (w_produce) begin
      r_valid <= 1'b1;
      r_last  <= w_frame_end;
    end else if (o_ready) begin
      r_valid <= 1'b0;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [DATA_W-1:0] w_a_out;
    logic [DATA_W-1:0] w_b_out;
    logic [DATA_W-1:0] w_col [WIN_K];
    logic [BUS_W-1:0]  w_bus;
    logic [DATA_W-1:0] r_hist [WIN_K][WIN_K-1];
    logic [BUS_W-1:0]  r_bus;

    line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb_a (
      .i_clk  (i_clk),
      .i_en   (w_accept),
      .i_data (w_pix[g]),
      .o_data (w_a_out)
    );

    line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb_b (
      .i_clk  (i_clk),
      .i_en   (w_accept),
      .i_data (w_a_out),
      .o_data (w_b_out)
    );

    assign w_col[0] = w_b_out;
    assign w_col[1] = w_a_out;
    assign w_col[2] = w_pix[g];

    // The window's newest column is taken live; only the two older columns are held here.
    always_comb begin
      w_bus = '0;
      for (int wr = 0; wr < WIN_K; wr++) begin
        for (int wc = 0; wc < WIN_K - 1; wc++) begin
          w_bus[elem_idx(wr, wc) * DATA_W +: DATA_W] = r_hist[wr][wc];
        end
        w_bus[elem_idx(wr, WIN_K - 1) * DATA_W +: DATA_W] = w_col[wr];
      end
    end

    always_ff @(posedge i_clk) begin
      if (w_accept) begin
        for (int wr = 0; wr < WIN_K; wr++) begin
          r_hist[wr][0] <= r_hist[wr][1];
          r_hist[wr][1] <= w_col[wr];
        end
      end
    end

    always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
        r_bus <= '0;
      end else if (w_produce) begin
        r_bus <= w_bus;
      end
    end
  end

  assign o_valid    = r_valid;
  assign o_last     = r_last;
  assign o_busData0 = g_ch[0].r_bus;
  assign o_busData1 = g_ch[1].r_bus;
  assign o_busData2 = g_ch[2].r_bus;

endmodule
